// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, hold, flush and a saturating stall counter.
// Latency 1 cycle; in_ready depends on registers only, dropping once the skid entry is occupied.
module pipe_stage_skid #(
  parameter int                 DATA_W             = 32,
  parameter int                 ADDR_W             = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE          = {DATA_W{1'b0}},
  parameter bit                 KEEP_ADDR_ON_FLUSH = 1'b1,
  parameter int                 CNT_W              = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_addr;

  logic [1:0] state;
  logic       accept;
  logic       fire;
  logic       main_load_in;
  logic       main_load_skid;
  logic       skid_load;
  logic       nxt_out_valid;
  logic       nxt_skid_valid;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready & ~hold;
  assign state    = {out_valid, skid_valid};

  always_comb begin
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    nxt_out_valid  = out_valid;
    nxt_skid_valid = skid_valid;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load_in  = 1'b1;
          nxt_out_valid = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_load_in = 1'b1;
        end else if (accept) begin
          skid_load      = 1'b1;
          nxt_skid_valid = 1'b1;
        end else if (fire) begin
          nxt_out_valid = 1'b0;
        end
      end
      ST_FULL: begin
        if (fire) begin
          main_load_skid = 1'b1;
          nxt_skid_valid = 1'b0;
        end
      end
      default: begin
        // skid without main is unreachable; collapse back to empty
        nxt_out_valid  = 1'b0;
        nxt_skid_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      out_valid  <= nxt_out_valid;
      skid_valid <= nxt_skid_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr <= NOP_VALUE;
      out_addr  <= '0;
    end else if (flush) begin
      out_instr <= NOP_VALUE;
      if (!KEEP_ADDR_ON_FLUSH) begin
        out_addr <= '0;
      end
    end else if (main_load_in) begin
      out_instr <= in_instr;
      out_addr  <= in_addr;
    end else if (main_load_skid) begin
      out_instr <= skid_instr;
      out_addr  <= skid_addr;
    end
  end

  // skid payload is only meaningful while skid_valid, so flush leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_instr <= '0;
      skid_addr  <= '0;
    end else if (!flush && skid_load) begin
      skid_instr <= in_instr;
      skid_addr  <= in_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !fire && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
